// File: rtl/adder_pkg.sv
// Shared types, constants and a reference model for the serial adder.
package adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    // FSM encoding; 2'd3 is unreachable and decodes as IDLE.
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Golden {cout, sum} for the default width.
    function automatic logic [DEFAULT_WIDTH:0] ref_add(
        input logic [DEFAULT_WIDTH-1:0] a,
        input logic [DEFAULT_WIDTH-1:0] b,
        input logic                     cin
    );
        logic [DEFAULT_WIDTH:0] r;
        r = {1'b0, a} + {1'b0, b} + {{DEFAULT_WIDTH{1'b0}}, cin};
        return r;
    endfunction

endpackage

// File: rtl/fa_bit.sv
// Combinational full adder built from two half adders and an OR.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

    assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder4.sv
// Bit-serial WIDTH-bit adder: one shared full-adder cell, LSB first,
// start/done handshake, result registered and held until the next completion.
module serial_adder4
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   sa;
    logic [WIDTH-1:0]   sb;
    logic [WIDTH-1:1]   acc;
    logic [WIDTH-1:0]   acc_nxt;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_s;
    logic               fa_co;
    logic               load_c;
    logic               step_c;
    logic               last_c;

    fa_bit u_fa (
        .a  (sa[0]),
        .b  (sb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB; the lowest bit falls out into the result.
    assign acc_nxt = {fa_s, acc};

    assign busy = (state == RUN) || (state == DONE);

    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        step_c    = 1'b0;
        last_c    = 1'b0;
        case (state)
            RUN: begin
                step_c = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last_c    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= last_c;
            if (load_c) begin
                sa    <= a;
                sb    <= b;
                carry <= cin;
                cnt   <= '0;
                acc   <= '0;
            end else if (step_c) begin
                sa    <= {1'b0, sa[WIDTH-1:1]};
                sb    <= {1'b0, sb[WIDTH-1:1]};
                carry <= fa_co;
                cnt   <= cnt + CNT_W'(1);
                acc   <= acc_nxt[WIDTH-1:1];
            end
            // Result registers move only on the completing bit.
            if (last_c) begin
                sum  <= acc_nxt;
                cout <= fa_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder4.sv
// Scoreboard bench for serial_adder4: directed vectors plus an exhaustive sweep.
module tb_serial_adder4;
    import adder_pkg::*;

    localparam int unsigned W = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    always #5 clk = ~clk;

    serial_adder4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    logic [W:0] exp_q[$];
    int         checks   = 0;
    int         errors   = 0;
    int         done_cnt = 0;
    int         issued   = 0;
    bit         mon_en   = 1'b0;
    logic [W:0] prev_res;
    logic       prev_done;
    logic       rst_q;

    always @(posedge clk) rst_q <= rst_n;

    // Monitor: pops the scoreboard on each done and guards result stability.
    always @(negedge clk) begin : monitor
        logic [W:0] e;
        if (mon_en) begin
            if (done === 1'b1) begin
                done_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done got=%0h (no operation pending)", {cout, sum});
                end else begin
                    e = exp_q.pop_front();
                    if ({cout, sum} !== e) begin
                        errors++;
                        $display("FAIL result got=%0h exp=%0h", {cout, sum}, e);
                    end
                end
                checks++;
                if (prev_done === 1'b1) begin
                    errors++;
                    $display("FAIL done_pulse_width got=2+ cycles exp=1");
                end
            end else if (rst_q === 1'b1) begin
                checks++;
                if ({cout, sum} !== prev_res) begin
                    errors++;
                    $display("FAIL result_stable got=%0h exp=%0h", {cout, sum}, prev_res);
                end
            end
            prev_res  = {cout, sum};
            prev_done = done;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Called at a negedge; returns at the first negedge after the accept edge.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input logic [W:0] exp, input bit push);
        wait_idle();
        a     = ta;
        b     = tb;
        cin   = tc;
        start = 1'b1;
        if (push) begin
            exp_q.push_back(exp);
            issued++;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges after the accept edge until done is seen.
    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tc, input logic [W:0] exp);
        int n;
        issue(ta, tb, tc, exp, 1'b1);
        chk({name, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        chk({name, "_latency"}, 32'(n), 32'(W + 1));
        @(negedge clk);
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int busy_cycles;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", 32'({busy, done, cout, sum}), 32'd0);
        rst_n     = 1'b1;
        prev_res  = {cout, sum};
        prev_done = done;
        mon_en    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outputs", 32'({busy, done, cout, sum}), 32'd0);
        end

        directed("add_3_5",    4'h3, 4'h5, 1'b0, 5'h08);
        directed("ripple_f_1", 4'hF, 4'h1, 1'b0, 5'h10);
        directed("ripple_f_f", 4'hF, 4'hF, 1'b1, 5'h1F);

        // Hammer start while busy; only the post-DONE idle cycle may accept.
        issue(4'h2, 4'h2, 1'b0, 5'h04, 1'b1);
        busy_cycles = 0;
        for (int i = 0; i < 50; i++) begin
            if (busy === 1'b1) begin
                start = 1'b1;
                a     = 4'hA;
                b     = 4'h5;
                busy_cycles++;
                @(negedge clk);
            end else begin
                break;
            end
        end
        chk("protect_busy_cycles", 32'(busy_cycles), 32'(W + 1));
        exp_q.push_back(5'h0F);
        issued++;
        @(negedge clk);
        start = 1'b0;
        chk("protect_accept", 32'(busy), 32'd1);
        wait_done(n);
        chk("protect_latency", 32'(n), 32'(W + 1));
        @(negedge clk);

        // Abort mid-run: reset on the second edge after acceptance.
        issue(4'h7, 4'h9, 1'b0, 5'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'({cout, sum}), 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        directed("after_abort", 4'h1, 4'h1, 1'b0, 5'h02);

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    issue(W'(ai), W'(bi), 1'(ci), ref_add(W'(ai), W'(bi), 1'(ci)), 1'b1);
                end
            end
        end
        wait_idle();
        repeat (3) @(negedge clk);
        chk("done_count", 32'(done_cnt), 32'(issued));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
